// File: rtl/ysyx_23060096_wb_arbiter.sv
// Writeback arbiter: merges EXU and LSU results into one registered register-file
// write port and tracks in-flight destinations for issue-stage hazard detection.
module ysyx_23060096_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    output logic                  exu_ready,
    input  logic                  lsu_valid,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,
    input  logic                  iss_set,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic [ADDR_WIDTH-1:0] iss_rs1,
    input  logic [ADDR_WIDTH-1:0] iss_rs2,
    output logic                  iss_stall,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam int NREGS = 1 << ADDR_WIDTH;

    logic                  rr;
    logic [NREGS-1:0]      pending;
    logic [NREGS-1:0]      pending_nxt;
    logic [NREGS-1:0]      set_mask;
    logic [NREGS-1:0]      clr_mask;
    logic                  acc_p0;
    logic                  conflict_p0;
    logic [ADDR_WIDTH-1:0] sel_rd_p0;
    logic [DATA_WIDTH-1:0] sel_data_p0;

    function automatic logic [NREGS-1:0] reg_onehot(input logic [ADDR_WIDTH-1:0] a);
        logic [NREGS-1:0] m;
        m    = '0;
        m[a] = 1'b1;
        return m;
    endfunction

    // Stage p0: combinational grant and request selection
    assign conflict_p0 = exu_valid && lsu_valid;
    assign exu_ready   = !rst && exu_valid && (!lsu_valid || !rr);
    assign lsu_ready   = !rst && lsu_valid && (!exu_valid || rr);
    assign acc_p0      = exu_ready || lsu_ready;
    assign sel_rd_p0   = lsu_ready ? lsu_rd   : exu_rd;
    assign sel_data_p0 = lsu_ready ? lsu_data : exu_data;

    // Hazard check reads only registered scoreboard state; bit 0 is never set.
    assign iss_stall = !rst && (pending[iss_rs1] || pending[iss_rs2] ||
                                (iss_set && pending[iss_rd]));

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (iss_set && !iss_stall && (iss_rd != '0))
            set_mask = reg_onehot(iss_rd);
        if (rf_wen)
            clr_mask = reg_onehot(rf_waddr);
        pending_nxt    = (pending & ~clr_mask) | set_mask;
        pending_nxt[0] = 1'b0;
    end

    // Stage p1: registered register-file write port, scoreboard and pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            rr       <= 1'b0;
            pending  <= '0;
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            if (conflict_p0)
                rr <= ~rr;
            pending <= pending_nxt;
            rf_wen  <= acc_p0 && (sel_rd_p0 != '0);
            if (acc_p0 && (sel_rd_p0 != '0)) begin
                rf_waddr <= sel_rd_p0;
                rf_wdata <= sel_data_p0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060096_wb_arbiter.sv
// Directed bench for the writeback arbiter: grants, rr fairness, scoreboard, reset.
module tb_ysyx_23060096_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid, lsu_valid, exu_ready, lsu_ready;
    logic [4:0]  exu_rd, lsu_rd, iss_rd, iss_rs1, iss_rs2, rf_waddr;
    logic [31:0] exu_data, lsu_data, rf_wdata;
    logic        iss_set, iss_stall, rf_wen;

    int checks = 0;
    int errors = 0;

    ysyx_23060096_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .iss_set(iss_set), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_stall(iss_stall),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exu_valid = 0; exu_rd = 0; exu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        iss_set = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        checks++;
        if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs: wen=%b waddr=%0d wdata=%h expected 0/0/0", rf_wen, rf_waddr, rf_wdata);
        end
        exu_valid = 1; lsu_valid = 1; iss_set = 1; iss_rd = 4;
        #1;
        checks++;
        if (exu_ready !== 1'b0 || lsu_ready !== 1'b0 || iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: exu_ready=%b lsu_ready=%b stall=%b expected 0/0/0", exu_ready, lsu_ready, iss_stall);
        end
        idle_inputs();
        rst = 0;
        #1;
    endtask

    task automatic test_exu_only();
        exu_valid = 1; exu_rd = 5; exu_data = 32'h1234_5678;
        #1;
        checks++;
        if (exu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL exu_only_ready: exu_ready=%b lsu_ready=%b expected 1/0", exu_ready, lsu_ready);
        end
        tick();
        exu_valid = 0;
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL exu_only_write: wen=%b waddr=%0d wdata=%h expected 1/5/12345678", rf_wen, rf_waddr, rf_wdata);
        end
        tick();
        checks++;
        if (rf_wen !== 1'b0 || rf_waddr !== 5'd5) begin
            errors++;
            $display("FAIL exu_only_idle: wen=%b waddr=%0d expected 0/5", rf_wen, rf_waddr);
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_addr [3];
        logic       exp_lsu  [3];
        exp_addr[0] = 1; exp_addr[1] = 2; exp_addr[2] = 1;
        exp_lsu[0]  = 0; exp_lsu[1]  = 1; exp_lsu[2]  = 0;
        do_reset();
        tick();
        exu_valid = 1; exu_rd = 1; exu_data = 32'hAAAA_0001;
        lsu_valid = 1; lsu_rd = 2; lsu_data = 32'hBBBB_0002;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (lsu_ready !== exp_lsu[i] || exu_ready !== !exp_lsu[i]) begin
                errors++;
                $display("FAIL rr_grant[%0d]: exu_ready=%b lsu_ready=%b expected lsu=%b", i, exu_ready, lsu_ready, exp_lsu[i]);
            end
            tick();
            checks++;
            if (rf_wen !== 1'b1 || rf_waddr !== exp_addr[i] ||
                rf_wdata !== (exp_lsu[i] ? 32'hBBBB_0002 : 32'hAAAA_0001)) begin
                errors++;
                $display("FAIL rr_write[%0d]: wen=%b waddr=%0d wdata=%h expected addr %0d", i, rf_wen, rf_waddr, rf_wdata, exp_addr[i]);
            end
        end
        // three conflicts leave rr favouring LSU; a lone EXU request must not move it
        lsu_valid = 0;
        tick();
        lsu_valid = 1;
        #1;
        checks++;
        if (lsu_ready !== 1'b1 || exu_ready !== 1'b0) begin
            errors++;
            $display("FAIL rr_single_hold: exu_ready=%b lsu_ready=%b expected 0/1", exu_ready, lsu_ready);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_scoreboard();
        do_reset();
        iss_set = 1; iss_rd = 7;
        #1;
        checks++;
        if (iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL sb_issue7: stall=%b expected 0", iss_stall);
        end
        tick();
        iss_set = 0; iss_rd = 0; iss_rs1 = 7;
        #1;
        checks++;
        if (iss_stall !== 1'b1) begin
            errors++;
            $display("FAIL sb_raw_rs1: stall=%b expected 1", iss_stall);
        end
        // stalled issue of rd=6 must not mark 6 pending
        iss_set = 1; iss_rd = 6;
        tick();
        iss_set = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 6;
        #1;
        checks++;
        if (iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL sb_stalled_noset: stall=%b expected 0", iss_stall);
        end
        iss_rs2 = 7;
        #1;
        checks++;
        if (iss_stall !== 1'b1) begin
            errors++;
            $display("FAIL sb_raw_rs2: stall=%b expected 1", iss_stall);
        end
        iss_rs2 = 0; iss_set = 1; iss_rd = 7;
        #1;
        checks++;
        if (iss_stall !== 1'b1) begin
            errors++;
            $display("FAIL sb_waw: stall=%b expected 1", iss_stall);
        end
        iss_set = 0; iss_rd = 0; iss_rs1 = 7;
        exu_valid = 1; exu_rd = 7; exu_data = 32'h0000_0077;
        tick();
        exu_valid = 0;
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || iss_stall !== 1'b1) begin
            errors++;
            $display("FAIL sb_commit_cycle: wen=%b waddr=%0d stall=%b expected 1/7/1", rf_wen, rf_waddr, iss_stall);
        end
        tick();
        checks++;
        if (iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL sb_cleared: stall=%b expected 0", iss_stall);
        end
        iss_rs1 = 0;
    endtask

    task automatic test_rd_zero();
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (lsu_ready !== 1'b1) begin
            errors++;
            $display("FAIL rd0_ready: lsu_ready=%b expected 1", lsu_ready);
        end
        tick();
        lsu_valid = 0;
        checks++;
        if (rf_wen !== 1'b0 || rf_waddr !== 5'd7 || rf_wdata !== 32'h0000_0077) begin
            errors++;
            $display("FAIL rd0_nowrite: wen=%b waddr=%0d wdata=%h expected 0/7/00000077", rf_wen, rf_waddr, rf_wdata);
        end
        iss_set = 1; iss_rd = 0;
        tick();
        iss_set = 0; iss_rs1 = 0; iss_rs2 = 0;
        #1;
        checks++;
        if (iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL rd0_nopending: stall=%b expected 0", iss_stall);
        end
    endtask

    task automatic test_set_over_clear();
        exu_valid = 1; exu_rd = 3; exu_data = 32'h0000_0033;
        tick();
        exu_valid = 0;
        iss_set = 1; iss_rd = 3;
        #1;
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd3 || iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL soc_setup: wen=%b waddr=%0d stall=%b expected 1/3/0", rf_wen, rf_waddr, iss_stall);
        end
        tick();
        iss_set = 0; iss_rd = 0; iss_rs1 = 3;
        #1;
        checks++;
        if (iss_stall !== 1'b1) begin
            errors++;
            $display("FAIL soc_pending3: stall=%b expected 1", iss_stall);
        end
        iss_rs1 = 0;
    endtask

    task automatic test_reset_in_flight();
        do_reset();
        exu_valid = 1; exu_rd = 1; lsu_valid = 1; lsu_rd = 2;
        tick();
        idle_inputs();
        iss_set = 1; iss_rd = 12;
        tick();
        iss_set = 0; iss_rd = 0;
        exu_valid = 1; exu_rd = 9; exu_data = 32'h9999_9999;
        tick();
        exu_valid = 0;
        rst = 1;
        iss_rs1 = 12;
        #1;
        checks++;
        if (iss_stall !== 1'b0 || rf_wen !== 1'b1) begin
            errors++;
            $display("FAIL rif_during: stall=%b wen=%b expected 0/1", iss_stall, rf_wen);
        end
        tick();
        rst = 0;
        #1;
        checks++;
        if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL rif_after: wen=%b waddr=%0d wdata=%h stall=%b expected 0/0/0/0", rf_wen, rf_waddr, rf_wdata, iss_stall);
        end
        exu_valid = 1; exu_rd = 1; lsu_valid = 1; lsu_rd = 2;
        #1;
        checks++;
        if (exu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL rif_rr: exu_ready=%b lsu_ready=%b expected 1/0", exu_ready, lsu_ready);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_exu_only();
        test_round_robin();
        test_scoreboard();
        test_rd_zero();
        test_set_over_clear();
        test_reset_in_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
